// File: rtl/mpi_pkg.sv
// Shared MPI bus definitions for master and slave sides: widths, bus state
// encoding and rw polarity constants.
package mpi_pkg;

  localparam int MPI_DW = 8;
  localparam int MPI_AW = 6;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } mpi_state_e;

endpackage

// File: rtl/mpi_master_if.sv
// Command/response port of the MPI bus master.
// Handshake: a command transfers on a posedge where Cmd_valid && Cmd_ready;
// the requester holds Cmd_valid and its payload stable until then. Rsp_valid
// is a one-cycle pulse with no back-pressure; Rsp_rdata/Rsp_err are
// qualified by it.
interface mpi_master_if;
  import mpi_pkg::*;

  logic              Cmd_valid;
  logic              Cmd_ready;
  logic              Cmd_rw;
  logic [MPI_AW-1:0] Cmd_addr;
  logic [MPI_DW-1:0] Cmd_wdata;
  logic              Rsp_valid;
  logic [MPI_DW-1:0] Rsp_rdata;
  logic              Rsp_err;

  // Requester side (controller or bench driver)
  modport master (
    output Cmd_valid, Cmd_rw, Cmd_addr, Cmd_wdata,
    input  Cmd_ready, Rsp_valid, Rsp_rdata, Rsp_err
  );

  // Bus-master block side
  modport slave (
    input  Cmd_valid, Cmd_rw, Cmd_addr, Cmd_wdata,
    output Cmd_ready, Rsp_valid, Rsp_rdata, Rsp_err
  );

endinterface

// File: rtl/mpi_master_timer.sv
// Loadable down-counter used to time each bus phase; Done is high while the
// count is zero, i.e. in the last cycle of the phase.
module mpi_master_timer #(
  parameter int W = 8
) (
  input  logic         Clock,
  input  logic         Rst,
  input  logic         Load,
  input  logic [W-1:0] Load_val,
  output logic         Done
);

  logic [W-1:0] count_q;

  always_ff @(posedge Clock) begin
    if (Rst) begin
      count_q <= '0;
    end else if (Load) begin
      count_q <= Load_val;
    end else if (count_q != '0) begin
      count_q <= count_q - W'(1);
    end
  end

  assign Done = (count_q == '0);

endmodule

// File: rtl/mpi_master.sv
// MPI bus master: turns local read/write commands into cs_n/rw/addr/data bus
// cycles with programmable setup/strobe/hold. Optional MPI_WR_VERIFY_EN adds a
// readback of every write and reports a mismatch on Rsp_err.
module mpi_master
  import mpi_pkg::*;
#(
  parameter int SETUP_CYC  = 2,
  parameter int STROBE_CYC = 4,
  parameter int HOLD_CYC   = 2
) (
  input  logic              Clock,
  input  logic              Rst,
  mpi_master_if.slave       cmd,
  output logic              Busy,
  inout  wire  [MPI_DW-1:0] Mpi_data,
  output logic [MPI_AW-1:0] Mpi_addr,
  output logic              Mpi_cs_n,
  output logic              Mpi_rw,
  output mpi_state_e        Dbg_state,
  output logic              Dbg_wr_oe
);

  localparam int TW = 8;
  localparam logic [TW-1:0] SETUP_LD  = TW'(SETUP_CYC - 1);
  localparam logic [TW-1:0] STROBE_LD = TW'(STROBE_CYC - 1);
  localparam logic [TW-1:0] HOLD_LD   = TW'(HOLD_CYC - 1);

  // The slave needs >=3 low cycles to see the strobe through its synchroniser
  // and >=3 high cycles (including the response cycle) to re-arm its edge detect.
  if (STROBE_CYC < 3 || SETUP_CYC < 1 || HOLD_CYC < 1 ||
      SETUP_CYC + HOLD_CYC < 2 || STROBE_CYC > 255 || SETUP_CYC > 255 ||
      HOLD_CYC > 255) begin : g_bad_timing
    $error("mpi_master: illegal SETUP_CYC/STROBE_CYC/HOLD_CYC combination");
  end

  mpi_state_e        state_q;
  logic              wr_oe_q;
  logic [MPI_DW-1:0] wdata_q;
  logic [MPI_DW-1:0] rdata_q;
`ifdef MPI_WR_VERIFY_EN
  logic              verify_q;
`endif

  logic              accept;
  logic              tmr_load;
  logic [TW-1:0]     tmr_val;
  logic              tmr_done;

  assign cmd.Cmd_ready = (state_q == IDLE);
  assign accept        = cmd.Cmd_valid && cmd.Cmd_ready;
  assign Busy          = (state_q != IDLE);
  assign Dbg_state     = state_q;
  assign Dbg_wr_oe     = wr_oe_q;
  assign Mpi_data      = wr_oe_q ? wdata_q : {MPI_DW{1'bz}};

  // Reload the phase timer on every state transition with the next phase length.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    unique case (state_q)
      IDLE:   begin tmr_load = accept;   tmr_val = SETUP_LD;  end
      SETUP:  begin tmr_load = tmr_done; tmr_val = STROBE_LD; end
      STROBE: begin tmr_load = tmr_done; tmr_val = HOLD_LD;   end
      HOLD:   begin tmr_load = tmr_done; tmr_val = SETUP_LD;  end
      default: ;
    endcase
  end

  mpi_master_timer #(.W(TW)) u_timer (
    .Clock    (Clock),
    .Rst      (Rst),
    .Load     (tmr_load),
    .Load_val (tmr_val),
    .Done     (tmr_done)
  );

  always_ff @(posedge Clock) begin
    if (Rst) begin
      state_q       <= IDLE;
      Mpi_cs_n      <= 1'b1;
      Mpi_rw        <= RW_READ;
      Mpi_addr      <= '0;
      wr_oe_q       <= 1'b0;
      wdata_q       <= '0;
      rdata_q       <= '0;
      cmd.Rsp_valid <= 1'b0;
      cmd.Rsp_rdata <= '0;
      cmd.Rsp_err   <= 1'b0;
`ifdef MPI_WR_VERIFY_EN
      verify_q      <= 1'b0;
`endif
    end else begin
      cmd.Rsp_valid <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            state_q  <= SETUP;
            Mpi_rw   <= cmd.Cmd_rw;
            Mpi_addr <= cmd.Cmd_addr;
            wdata_q  <= cmd.Cmd_wdata;
            wr_oe_q  <= (cmd.Cmd_rw == RW_WRITE);
`ifdef MPI_WR_VERIFY_EN
            verify_q <= 1'b0;
`endif
          end
        end
        SETUP: begin
          if (tmr_done) begin
            state_q  <= STROBE;
            Mpi_cs_n <= 1'b0;
          end
        end
        STROBE: begin
          if (tmr_done) begin
            state_q  <= HOLD;
            Mpi_cs_n <= 1'b1;
            if (Mpi_rw == RW_READ) rdata_q <= Mpi_data;
          end
        end
        HOLD: begin
          if (tmr_done) begin
            wr_oe_q <= 1'b0;
`ifdef MPI_WR_VERIFY_EN
            if (Mpi_rw == RW_WRITE) begin
              // Turn the finished write into a readback of the same address.
              state_q  <= SETUP;
              Mpi_rw   <= RW_READ;
              verify_q <= 1'b1;
            end else begin
              state_q       <= IDLE;
              cmd.Rsp_valid <= 1'b1;
              cmd.Rsp_rdata <= rdata_q;
              cmd.Rsp_err   <= verify_q && (rdata_q != wdata_q);
            end
`else
            state_q       <= IDLE;
            cmd.Rsp_valid <= 1'b1;
            cmd.Rsp_rdata <= (Mpi_rw == RW_READ) ? rdata_q : '0;
            cmd.Rsp_err   <= 1'b0;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
